// File: rtl/regfile_wb_arbiter.sv
// Arbitrates RegFile writeback between the pipeline and a 2-entry FIFO of multicycle results,
// with starvation forcing, address-0 suppression, read bypass and FIFO hazard flags.
module regfile_wb_arbiter #(
  parameter int REG_ADDR_LEN = 5,
  parameter int REG_LENGTH   = 32,
  parameter int STARVE_LIM   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_we,
  input  logic [REG_ADDR_LEN-1:0] p_addr,
  input  logic [REG_LENGTH-1:0]   p_data,
  output logic                    p_stall,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [REG_ADDR_LEN-1:0] m_addr,
  input  logic [REG_LENGTH-1:0]   m_data,
  output logic                    we,
  output logic [REG_ADDR_LEN-1:0] wAddr,
  output logic [REG_LENGTH-1:0]   wData,
  input  logic [REG_ADDR_LEN-1:0] regaAddr,
  input  logic [REG_ADDR_LEN-1:0] regbAddr,
  input  logic [REG_LENGTH-1:0]   regaRf,
  input  logic [REG_LENGTH-1:0]   regbRf,
  output logic [REG_LENGTH-1:0]   regaData,
  output logic [REG_LENGTH-1:0]   regbData,
  output logic                    hazA,
  output logic                    hazB
);

  logic [REG_ADDR_LEN-1:0] r_mem_addr [2];
  logic [REG_LENGTH-1:0]   r_mem_data [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [3:0]              r_wait_cnt;

  logic                    w_nonempty;
  logic                    w_full_tail;
  logic                    w_tail_idx;
  logic                    w_force;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_sel_vld;
  logic [REG_ADDR_LEN-1:0] w_sel_addr;
  logic [REG_LENGTH-1:0]   w_sel_data;
  logic                    w_we;

  function automatic logic [REG_LENGTH-1:0] bypass(
    input logic                    wr_en,
    input logic [REG_ADDR_LEN-1:0] wr_addr,
    input logic [REG_LENGTH-1:0]   wr_data,
    input logic [REG_ADDR_LEN-1:0] rd_addr,
    input logic [REG_LENGTH-1:0]   rd_rf
  );
    return (wr_en && (wr_addr == rd_addr) && (rd_addr != '0)) ? wr_data : rd_rf;
  endfunction

  assign w_nonempty  = (r_count != 2'd0);
  assign w_full_tail = (r_count == 2'd2);
  assign w_tail_idx  = ~r_rd_ptr;
  assign w_force     = (r_wait_cnt == 4'(STARVE_LIM));
  assign m_ready     = !rst && (r_count < 2'd2);
  assign w_push      = m_valid && m_ready;

  always_comb begin
    w_pop      = 1'b0;
    w_sel_vld  = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    p_stall    = 1'b0;
    if (!rst) begin
      if (w_force && w_nonempty) begin
        w_pop      = 1'b1;
        w_sel_vld  = 1'b1;
        w_sel_addr = r_mem_addr[r_rd_ptr];
        w_sel_data = r_mem_data[r_rd_ptr];
        p_stall    = p_we;
      end else if (p_we) begin
        w_sel_vld  = 1'b1;
        w_sel_addr = p_addr;
        w_sel_data = p_data;
      end else if (w_nonempty) begin
        w_pop      = 1'b1;
        w_sel_vld  = 1'b1;
        w_sel_addr = r_mem_addr[r_rd_ptr];
        w_sel_data = r_mem_data[r_rd_ptr];
      end
    end
  end

  // Writes to address 0 still consume the request but never reach the RegFile.
  assign w_we  = w_sel_vld && (w_sel_addr != '0);
  assign we    = w_we;
  assign wAddr = w_we ? w_sel_addr : '0;
  assign wData = w_we ? w_sel_data : '0;

  assign regaData = bypass(w_we, wAddr, wData, regaAddr, regaRf);
  assign regbData = bypass(w_we, wAddr, wData, regbAddr, regbRf);

  assign hazA = !rst && (regaAddr != '0) &&
                ((w_nonempty  && (r_mem_addr[r_rd_ptr]   == regaAddr)) ||
                 (w_full_tail && (r_mem_addr[w_tail_idx] == regaAddr)));
  assign hazB = !rst && (regbAddr != '0) &&
                ((w_nonempty  && (r_mem_addr[r_rd_ptr]   == regbAddr)) ||
                 (w_full_tail && (r_mem_addr[w_tail_idx] == regbAddr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (!w_nonempty || w_pop)
        r_wait_cnt <= 4'd0;
      else if (!w_force)
        r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // FIFO storage carries data only; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= m_addr;
      r_mem_data[r_wr_ptr] <= m_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, pipeline path, FIFO latency, full,
// starvation forcing, address-0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        p_stall;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        we;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic [4:0]  regaAddr, regbAddr;
  logic [31:0] regaRf, regbRf, regaData, regbData;
  logic        hazA, hazB;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.REG_ADDR_LEN(5), .REG_LENGTH(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_stall(p_stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .we(we), .wAddr(wAddr), .wData(wData),
    .regaAddr(regaAddr), .regbAddr(regbAddr), .regaRf(regaRf), .regbRf(regbRf),
    .regaData(regaData), .regbData(regbData), .hazA(hazA), .hazB(hazB)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_we = 0; p_addr = 0; p_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    regaAddr = 0; regbAddr = 0; regaRf = 32'hDEAD_0001; regbRf = 32'hDEAD_0002;
  endtask

  task automatic test_reset();
    rst = 1; p_we = 1; p_addr = 5; p_data = 32'h1111;
    m_valid = 1; m_addr = 6; m_data = 32'h2222;
    regaAddr = 5; regbAddr = 6; regaRf = 32'h0A0A; regbRf = 32'h0B0B;
    cyc(); cyc();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL rst_we got %0h exp 0", we); end
    tests++; if (wAddr !== 5'd0 || wData !== 32'd0) begin fails++; $display("FAIL rst_wbus got %0h/%0h exp 0/0", wAddr, wData); end
    tests++; if (m_ready !== 1'b0) begin fails++; $display("FAIL rst_m_ready got %0h exp 0", m_ready); end
    tests++; if (p_stall !== 1'b0) begin fails++; $display("FAIL rst_p_stall got %0h exp 0", p_stall); end
    tests++; if (hazA !== 1'b0 || hazB !== 1'b0) begin fails++; $display("FAIL rst_haz got %0h%0h exp 00", hazA, hazB); end
    tests++; if (regaData !== 32'h0A0A) begin fails++; $display("FAIL rst_bypass got %0h exp a0a", regaData); end
    rst = 0; idle(); #1;
    tests++; if (m_ready !== 1'b1 || we !== 1'b0) begin fails++; $display("FAIL rst_exit got rdy=%0h we=%0h exp 1/0", m_ready, we); end
    cyc();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL rst_nowrite got %0h exp 0", we); end
  endtask

  task automatic test_pipeline();
    p_we = 1; p_addr = 5; p_data = 32'h1234; regaAddr = 5; regbAddr = 6; #1;
    tests++; if (we !== 1'b1 || wAddr !== 5'd5 || wData !== 32'h1234) begin fails++; $display("FAIL pipe_write got %0h/%0h/%0h exp 1/5/1234", we, wAddr, wData); end
    tests++; if (p_stall !== 1'b0) begin fails++; $display("FAIL pipe_stall got %0h exp 0", p_stall); end
    tests++; if (regaData !== 32'h1234) begin fails++; $display("FAIL pipe_bypassA got %0h exp 1234", regaData); end
    tests++; if (regbData !== 32'hDEAD_0002) begin fails++; $display("FAIL pipe_noBypassB got %0h exp dead0002", regbData); end
    cyc(); idle(); #1;
  endtask

  task automatic test_fifo_latency();
    m_valid = 1; m_addr = 7; m_data = 32'hAA; regaAddr = 7; #1;
    tests++; if (we !== 1'b0 || hazA !== 1'b0) begin fails++; $display("FAIL lat_pushcycle got we=%0h haz=%0h exp 0/0", we, hazA); end
    cyc(); m_valid = 0; #1;
    tests++; if (we !== 1'b1 || wAddr !== 5'd7 || wData !== 32'hAA) begin fails++; $display("FAIL lat_write got %0h/%0h/%0h exp 1/7/aa", we, wAddr, wData); end
    tests++; if (hazA !== 1'b1) begin fails++; $display("FAIL lat_hazA got %0h exp 1", hazA); end
    tests++; if (regaData !== 32'hAA) begin fails++; $display("FAIL lat_bypass got %0h exp aa", regaData); end
    cyc();
    tests++; if (hazA !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL lat_after got haz=%0h we=%0h exp 0/0", hazA, we); end
    idle(); #1;
  endtask

  task automatic test_full();
    p_we = 1; p_addr = 1; p_data = 32'h100;
    m_valid = 1; m_addr = 10; m_data = 32'hA0; #1;
    tests++; if (m_ready !== 1'b1 || wAddr !== 5'd1) begin fails++; $display("FAIL full_c0 got rdy=%0h wa=%0h exp 1/1", m_ready, wAddr); end
    cyc(); m_addr = 11; m_data = 32'hB0; #1;
    tests++; if (m_ready !== 1'b1 || wAddr !== 5'd1 || p_stall !== 1'b0) begin fails++; $display("FAIL full_c1 got rdy=%0h wa=%0h st=%0h exp 1/1/0", m_ready, wAddr, p_stall); end
    cyc(); m_addr = 12; m_data = 32'hC0; #1;
    for (int c = 2; c <= 4; c++) begin
      tests++; if (m_ready !== 1'b0 || wAddr !== 5'd1) begin fails++; $display("FAIL full_wait%0d got rdy=%0h wa=%0h exp 0/1", c, m_ready, wAddr); end
      cyc();
    end
    tests++; if (wAddr !== 5'd10 || wData !== 32'hA0 || p_stall !== 1'b1 || m_ready !== 1'b0) begin fails++; $display("FAIL full_force got wa=%0h wd=%0h st=%0h rdy=%0h exp a/a0/1/0", wAddr, wData, p_stall, m_ready); end
    cyc();
    tests++; if (m_ready !== 1'b1 || wAddr !== 5'd1 || p_stall !== 1'b0) begin fails++; $display("FAIL full_c6 got rdy=%0h wa=%0h st=%0h exp 1/1/0", m_ready, wAddr, p_stall); end
    cyc(); m_valid = 0; p_we = 0; #1;
    tests++; if (wAddr !== 5'd11 || wData !== 32'hB0 || m_ready !== 1'b0) begin fails++; $display("FAIL full_popB got wa=%0h wd=%0h rdy=%0h exp b/b0/0", wAddr, wData, m_ready); end
    cyc();
    tests++; if (wAddr !== 5'd12 || wData !== 32'hC0 || m_ready !== 1'b1) begin fails++; $display("FAIL full_popC got wa=%0h wd=%0h rdy=%0h exp c/c0/1", wAddr, wData, m_ready); end
    cyc();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL full_drained got %0h exp 0", we); end
    idle(); #1;
  endtask

  task automatic test_starve();
    p_we = 1; p_addr = 3; p_data = 32'h300;
    m_valid = 1; m_addr = 9; m_data = 32'h99; regbAddr = 9; #1;
    tests++; if (wAddr !== 5'd3 || hazB !== 1'b0) begin fails++; $display("FAIL starve_push got wa=%0h hb=%0h exp 3/0", wAddr, hazB); end
    cyc(); m_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      p_data = 32'h300 + 32'(c); #1;
      tests++; if (wAddr !== 5'd3 || wData !== 32'h300 + 32'(c) || p_stall !== 1'b0 || hazB !== 1'b1) begin fails++; $display("FAIL starve_pipe%0d got wa=%0h wd=%0h st=%0h hb=%0h exp 3/%0h/0/1", c, wAddr, wData, p_stall, hazB, 32'h300 + 32'(c)); end
      cyc();
    end
    tests++; if (we !== 1'b1 || wAddr !== 5'd9 || wData !== 32'h99 || p_stall !== 1'b1) begin fails++; $display("FAIL starve_force got we=%0h wa=%0h wd=%0h st=%0h exp 1/9/99/1", we, wAddr, wData, p_stall); end
    cyc();
    tests++; if (wAddr !== 5'd3 || p_stall !== 1'b0 || hazB !== 1'b0) begin fails++; $display("FAIL starve_after got wa=%0h st=%0h hb=%0h exp 3/0/0", wAddr, p_stall, hazB); end
    cyc(); idle(); #1;
  endtask

  task automatic test_zero();
    p_we = 1; p_addr = 0; p_data = 32'h77; regaAddr = 0; regaRf = 32'h55; #1;
    tests++; if (we !== 1'b0 || p_stall !== 1'b0 || wAddr !== 5'd0 || wData !== 32'd0) begin fails++; $display("FAIL zero_pipe got we=%0h st=%0h wa=%0h wd=%0h exp 0/0/0/0", we, p_stall, wAddr, wData); end
    tests++; if (regaData !== 32'h55) begin fails++; $display("FAIL zero_read got %0h exp 55", regaData); end
    p_addr = 2; m_valid = 1; m_addr = 0; m_data = 32'hEE;
    cyc(); m_addr = 13; m_data = 32'hD0; regbAddr = 13; #1;
    tests++; if (hazA !== 1'b0 || hazB !== 1'b0) begin fails++; $display("FAIL zero_haz got %0h%0h exp 00", hazA, hazB); end
    cyc(); m_valid = 0; p_we = 0; #1;
    tests++; if (we !== 1'b0 || hazB !== 1'b1) begin fails++; $display("FAIL zero_pop got we=%0h hb=%0h exp 0/1", we, hazB); end
    cyc();
    tests++; if (we !== 1'b1 || wAddr !== 5'd13 || wData !== 32'hD0) begin fails++; $display("FAIL zero_next got %0h/%0h/%0h exp 1/d/d0", we, wAddr, wData); end
    cyc(); idle(); #1;
  endtask

  task automatic test_reset_mid();
    p_we = 1; p_addr = 2; p_data = 32'h22; m_valid = 1; m_addr = 20; m_data = 32'h20;
    cyc(); m_addr = 21; m_data = 32'h21;
    cyc(); m_valid = 0; rst = 1; regaAddr = 20; #1;
    tests++; if (hazA !== 1'b0 || we !== 1'b0 || m_ready !== 1'b0) begin fails++; $display("FAIL mid_rst got ha=%0h we=%0h rdy=%0h exp 0/0/0", hazA, we, m_ready); end
    cyc(); rst = 0; p_we = 0; #1;
    tests++; if (we !== 1'b0 || m_ready !== 1'b1 || hazA !== 1'b0) begin fails++; $display("FAIL mid_after got we=%0h rdy=%0h ha=%0h exp 0/1/0", we, m_ready, hazA); end
    cyc();
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL mid_dropped got %0h exp 0", we); end
    idle(); #1;
  endtask

  initial begin
    idle();
    test_reset();
    test_pipeline();
    test_fifo_latency();
    test_full();
    test_starve();
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
